// File: rtl/multi_sel_pkg.sv
// Shared definitions for the multi_sel multiplier sequencer and its feeder.
// Holds the data widths, the phase count and the phase-to-multiplier encoding.
package multi_sel_pkg;

    localparam int DATA_W     = 8;
    localparam int PROD_W     = DATA_W + 3;
    localparam int NUM_PHASES = 4;

    typedef enum logic [1:0] {
        PH_X1 = 2'b00,
        PH_X3 = 2'b01,
        PH_X7 = 2'b10,
        PH_X8 = 2'b11
    } phase_e;

    function automatic logic [3:0] phase_mult(input phase_e ph);
        case (ph)
            PH_X1:   phase_mult = 4'd1;
            PH_X3:   phase_mult = 4'd3;
            PH_X7:   phase_mult = 4'd7;
            default: phase_mult = 4'd8;
        endcase
    endfunction

endpackage

// File: rtl/multi_sel_fifo.sv
// Plain synchronous FIFO: write/read pointers, occupancy level, full/empty.
// The head entry is exposed combinationally so the wrapper can register it.
module multi_sel_fifo
    import multi_sel_pkg::*;
#(
    parameter int DATA_W = multi_sel_pkg::DATA_W,
    parameter int DEPTH  = 4,
    localparam int AW    = $clog2(DEPTH),
    localparam int LW    = AW + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    output logic [DATA_W-1:0] head,
    output logic [LW-1:0]     level,
    output logic              full,
    output logic              empty
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr_reg;
    logic [AW-1:0]     rd_ptr_reg;
    logic [LW-1:0]     level_reg;
    logic [DEPTH-1:0]  entry_we;
    logic              push;
    logic              pop;

    assign full  = (level_reg == LW'(DEPTH));
    assign empty = (level_reg == '0);
    assign push  = wr_en && !full;
    assign pop   = rd_en && !empty;
    assign head  = mem[rd_ptr_reg];
    assign level = level_reg;

    // One-hot write enable per entry; pointers wrap naturally since DEPTH is a power of two.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_we
            assign entry_we[gi] = push && (wr_ptr_reg == AW'(gi));
        end
    endgenerate

    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (entry_we[i]) begin
                mem[i] <= wr_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            level_reg  <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            end
            case ({push, pop})
                2'b10:   level_reg <= level_reg + LW'(1);
                2'b01:   level_reg <= level_reg - LW'(1);
                default: level_reg <= level_reg;
            endcase
        end
    end

endmodule

// File: rtl/multi_sel_feeder.sv
// Feeds buffered bytes to multi_sel on d; retires the head on input_grant and counts underruns.
// Build option MULTI_SEL_FEEDER_HOLD_LAST_EN: an empty FIFO keeps the last popped word on d.
module multi_sel_feeder
    import multi_sel_pkg::*;
#(
    parameter int DATA_W = multi_sel_pkg::DATA_W,
    parameter int DEPTH  = 4,
    parameter int UCNT_W = 8,
    localparam int LW    = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              input_grant,
    output logic [DATA_W-1:0] d,
    output logic [LW-1:0]     level,
    output logic [UCNT_W-1:0] underrun_cnt,
    output logic              overflow
);

    logic [DATA_W-1:0] head;
    logic              full;
    logic              empty;
    logic              pres_valid_q_reg;
    logic [DATA_W-1:0] d_reg;
    logic [UCNT_W-1:0] ucnt_reg;
    logic              overflow_reg;

    multi_sel_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (in_valid),
        .wr_data (in_data),
        .rd_en   (input_grant && pres_valid_q_reg),
        .head    (head),
        .level   (level),
        .full    (full),
        .empty   (empty)
    );

    assign in_ready     = !full;
    assign d            = d_reg;
    assign underrun_cnt = ucnt_reg;
    assign overflow     = overflow_reg;

    // pres_valid_q remembers whether d held real data when multi_sel sampled it,
    // so the grant that follows one cycle later pops only a word that was actually seen.
    always_ff @(posedge clk) begin
        if (rst) begin
            pres_valid_q_reg <= 1'b0;
            d_reg            <= '0;
            ucnt_reg         <= '0;
            overflow_reg     <= 1'b0;
        end else begin
            pres_valid_q_reg <= !empty;
            if (input_grant && !pres_valid_q_reg && (ucnt_reg != '1)) begin
                ucnt_reg <= ucnt_reg + UCNT_W'(1);
            end
            if (in_valid && full) begin
                overflow_reg <= 1'b1;
            end
            if (!empty) begin
                d_reg <= head;
            end else begin
`ifdef MULTI_SEL_FEEDER_HOLD_LAST_EN
                d_reg <= d_reg;
`else
                d_reg <= '0;
`endif
            end
        end
    end

endmodule
